// File: rtl/sync_sched.sv
// sync_sched: sequences the transmit phase, then the receive phase, of the
// inter-FPGA sync datapath. The two phases share one AFPGA address bus, so
// at most one of them owns it at a time, and a guard gap of unowned cycles
// separates them. The block also watches each wait for a hang and latches a
// fault.
// Optional statistics counters are built only when SYNC_SCHED_STAT_EN is
// defined; otherwise overrun_cnt and cycle_cnt are tied to zero.
// Every output comes straight from a flop, loaded from the next-state decode.
module sync_sched #(
    parameter int GUARD_CYC = 4,   // unowned cycles between phases, 1..15
    parameter int TIMEOUT_W = 12   // a wait times out after 2^TIMEOUT_W-1 cycles
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        cycle_start,
    input  logic        rx_frame_valid,
    input  logic [1:0]  btoa_sel,
    input  logic        trans_done,
    input  logic        recv_done,
    input  logic        fault_clr,
    output logic        sync_trans_en,
    output logic        sync_recv_en,
    output logic [1:0]  sync_Btoa_en,
    output logic [1:0]  afpga_owner,
    output logic        tx_ready,
    output logic        busy,
    output logic        timeout_err,
    output logic        fault,
    output logic [7:0]  overrun_cnt,
    output logic [15:0] cycle_cnt
);

    typedef enum logic [2:0] {
        S_IDLE, S_T_START, S_T_WAIT, S_G1, S_R_START, S_R_WAIT, S_G2, S_FAULT
    } state_t;

    localparam logic [3:0]           GUARD_LAST = 4'(GUARD_CYC - 1);
    // The counter reaches all-ones on the edge that ends this count.
    localparam logic [TIMEOUT_W-1:0] TO_LAST    = TIMEOUT_W'((1 << TIMEOUT_W) - 2);

    state_t               r_state;
    state_t               w_next;
    logic                 w_timeout;
    logic                 w_tx_done;
    logic [3:0]           r_gcnt;
    logic [TIMEOUT_W-1:0] r_tcnt;
    logic                 r_rx_pend;
    logic [1:0]           r_dir_q;

    // State register.
    always_ff @(posedge clk) begin
        // NOTE: every flop is updated with <= so all of them sample the
        // pre-edge values and the block order does not matter.
        if (reset) r_state <= S_IDLE;
        else       r_state <= w_next;
    end

    // Next-state logic with the done, guard and timeout decisions.
    always_comb begin
        // NOTE: defaults first, so no path leaves a signal unassigned and
        // no latch is inferred.
        w_next    = r_state;
        w_timeout = 1'b0;
        w_tx_done = 1'b0;
        case (r_state)
            S_IDLE:    if (cycle_start) w_next = S_T_START;
            S_T_START: begin
                w_next    = trans_done ? S_G1 : S_T_WAIT;
                w_tx_done = trans_done;
            end
            S_T_WAIT: begin
                if (trans_done) begin
                    w_next    = S_G1;
                    w_tx_done = 1'b1;
                end else if (r_tcnt == TO_LAST) begin
                    w_next    = S_FAULT;
                    w_timeout = 1'b1;
                end
            end
            S_G1: begin
                if (r_gcnt == GUARD_LAST) w_next = r_rx_pend ? S_R_START : S_IDLE;
            end
            S_R_START: w_next = recv_done ? S_G2 : S_R_WAIT;
            S_R_WAIT: begin
                if (recv_done) begin
                    w_next = S_G2;
                end else if (r_tcnt == TO_LAST) begin
                    w_next    = S_FAULT;
                    w_timeout = 1'b1;
                end
            end
            S_G2:      if (r_gcnt == GUARD_LAST) w_next = S_IDLE;
            S_FAULT:   if (fault_clr) w_next = S_IDLE;
            default:   w_next = S_IDLE;
        endcase
    end

    // Phase bookkeeping and registered outputs, loaded from the next state.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_gcnt        <= '0;
            r_tcnt        <= '0;
            r_rx_pend     <= 1'b0;
            r_dir_q       <= 2'b00;
            sync_trans_en <= 1'b0;
            sync_recv_en  <= 1'b0;
            sync_Btoa_en  <= 2'b00;
            afpga_owner   <= 2'b00;
            tx_ready      <= 1'b0;
            busy          <= 1'b0;
            timeout_err   <= 1'b0;
            fault         <= 1'b0;
        end else begin
            r_gcnt <= ((r_state == S_G1 || r_state == S_G2) && w_next == r_state)
                      ? r_gcnt + 4'd1 : 4'd0;
            // Held at zero in the start states, so each wait begins from zero.
            r_tcnt <= (r_state == S_T_WAIT || r_state == S_R_WAIT)
                      ? r_tcnt + TIMEOUT_W'(1) : '0;
            // A new frame beats the clear, so it is serviced next control cycle.
            if (rx_frame_valid)          r_rx_pend <= 1'b1;
            else if (r_state == S_R_START) r_rx_pend <= 1'b0;
            if (r_state == S_IDLE && cycle_start) r_dir_q <= btoa_sel;

            sync_trans_en <= (w_next == S_T_START);
            sync_recv_en  <= (w_next == S_R_START);
            afpga_owner   <= (w_next == S_T_START || w_next == S_T_WAIT) ? 2'b01 :
                             (w_next == S_R_START || w_next == S_R_WAIT) ? 2'b10 : 2'b00;
            sync_Btoa_en  <= (w_next == S_R_START || w_next == S_R_WAIT) ? r_dir_q : 2'b00;
            tx_ready      <= w_tx_done;
            busy          <= (w_next != S_IDLE);
            timeout_err   <= w_timeout;
            if (w_timeout)                           fault <= 1'b1;
            else if (r_state == S_FAULT && fault_clr) fault <= 1'b0;
        end
    end

`ifdef SYNC_SCHED_STAT_EN
    logic [7:0]  r_overrun_cnt;
    logic [15:0] r_cycle_cnt;
    logic        w_cycle_done;

    assign w_cycle_done = (r_state == S_G1 || r_state == S_G2) && (w_next == S_IDLE);

    // Overrun count saturates; completed-cycle count wraps.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_overrun_cnt <= 8'd0;
            r_cycle_cnt   <= 16'd0;
        end else begin
            if (cycle_start && r_state != S_IDLE && r_overrun_cnt != 8'hFF)
                r_overrun_cnt <= r_overrun_cnt + 8'd1;
            if (w_cycle_done) r_cycle_cnt <= r_cycle_cnt + 16'd1;
        end
    end

    assign overrun_cnt = r_overrun_cnt;
    assign cycle_cnt   = r_cycle_cnt;
`else
    assign overrun_cnt = 8'd0;
    assign cycle_cnt   = 16'd0;
`endif

endmodule

// File: tb/tb_sync_sched.sv
// tb_sync_sched: directed bench for sync_sched with GUARD_CYC=4, TIMEOUT_W=4.
// Each scenario steps cycle by cycle. The bench checks the outputs of the
// current cycle, then drives the inputs for that cycle. The cycle numbers
// used in the expectations are relative to the start of each scenario.
module tb_sync_sched;

    localparam int GUARD = 4;
`ifdef SYNC_SCHED_STAT_EN
    localparam bit STAT = 1'b1;
`else
    localparam bit STAT = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        cycle_start = 1'b0;
    logic        rx_frame_valid = 1'b0;
    logic [1:0]  btoa_sel = 2'b00;
    logic        trans_done = 1'b0;
    logic        recv_done = 1'b0;
    logic        fault_clr = 1'b0;
    logic        sync_trans_en, sync_recv_en, tx_ready, busy, timeout_err, fault;
    logic [1:0]  sync_Btoa_en, afpga_owner;
    logic [7:0]  overrun_cnt;
    logic [15:0] cycle_cnt;

    int n_checks = 0;
    int n_errors = 0;

    sync_sched #(.GUARD_CYC(GUARD), .TIMEOUT_W(4)) dut (
        .clk(clk), .reset(reset), .cycle_start(cycle_start),
        .rx_frame_valid(rx_frame_valid), .btoa_sel(btoa_sel),
        .trans_done(trans_done), .recv_done(recv_done), .fault_clr(fault_clr),
        .sync_trans_en(sync_trans_en), .sync_recv_en(sync_recv_en),
        .sync_Btoa_en(sync_Btoa_en), .afpga_owner(afpga_owner),
        .tx_ready(tx_ready), .busy(busy), .timeout_err(timeout_err),
        .fault(fault), .overrun_cnt(overrun_cnt), .cycle_cnt(cycle_cnt)
    );

    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish, got running exp finished");
        $fatal(1, "watchdog");
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        {cycle_start, rx_frame_valid, trans_done, recv_done, fault_clr} = '0;
        btoa_sel = 2'b00;
        reset = 1'b1;
        step();
        step();
        reset = 1'b0;
    endtask

    task automatic test_reset();
        logic [33:0] all_out;
        do_reset();
        all_out = {sync_trans_en, sync_recv_en, sync_Btoa_en, afpga_owner, tx_ready,
                   busy, timeout_err, fault, overrun_cnt, cycle_cnt};
        n_checks++;
        if (all_out !== 34'd0) begin
            n_errors++;
            $display("FAIL reset_outputs got %h exp 0", all_out);
        end
        cycle_start = 1'b1;
        step();
        cycle_start = 1'b0;
        n_checks++;
        if ({sync_trans_en, afpga_owner, busy} !== 4'b1011) begin
            n_errors++;
            $display("FAIL reset_start got %b exp 1011", {sync_trans_en, afpga_owner, busy});
        end
        step();
        reset = 1'b1;
        step();
        reset = 1'b0;
        all_out = {sync_trans_en, sync_recv_en, sync_Btoa_en, afpga_owner, tx_ready,
                   busy, timeout_err, fault, overrun_cnt, cycle_cnt};
        n_checks++;
        if (all_out !== 34'd0) begin
            n_errors++;
            $display("FAIL reset_midop got %h exp 0", all_out);
        end
    endtask

    task automatic test_tx_only();
        logic [1:0] e_own;
        do_reset();
        for (int t = 10; t <= 27; t++) begin
            e_own = (t >= 11 && t <= 20) ? 2'b01 : 2'b00;
            n_checks++;
            if (sync_trans_en !== (t == 11)) begin
                n_errors++;
                $display("FAIL tx_trans_en t=%0d got %b exp %b", t, sync_trans_en, t == 11);
            end
            n_checks++;
            if (tx_ready !== (t == 21)) begin
                n_errors++;
                $display("FAIL tx_ready t=%0d got %b exp %b", t, tx_ready, t == 21);
            end
            n_checks++;
            if (busy !== (t >= 11 && t <= 24)) begin
                n_errors++;
                $display("FAIL tx_busy t=%0d got %b exp %b", t, busy, t >= 11 && t <= 24);
            end
            n_checks++;
            if (afpga_owner !== e_own || sync_recv_en !== 1'b0) begin
                n_errors++;
                $display("FAIL tx_owner t=%0d got %b/%b exp %b/0", t, afpga_owner, sync_recv_en, e_own);
            end
            cycle_start = (t == 10);
            trans_done  = (t == 20);
            step();
        end
        {cycle_start, trans_done} = '0;
        n_checks++;
        if (cycle_cnt !== (STAT ? 16'd1 : 16'd0)) begin
            n_errors++;
            $display("FAIL tx_cycle_cnt got %0d exp %0d", cycle_cnt, STAT ? 1 : 0);
        end
    endtask

    task automatic test_full_cycle();
        logic [1:0] e_own;
        do_reset();
        btoa_sel = 2'b10;
        for (int t = 5; t <= 47; t++) begin
            e_own = (t >= 11 && t <= 20) ? 2'b01 : (t >= 25 && t <= 40) ? 2'b10 : 2'b00;
            n_checks++;
            if (afpga_owner !== e_own) begin
                n_errors++;
                $display("FAIL full_owner t=%0d got %b exp %b", t, afpga_owner, e_own);
            end
            n_checks++;
            if (sync_Btoa_en !== ((e_own == 2'b10) ? 2'b10 : 2'b00)) begin
                n_errors++;
                $display("FAIL full_btoa t=%0d got %b exp %b", t, sync_Btoa_en,
                         (e_own == 2'b10) ? 2'b10 : 2'b00);
            end
            n_checks++;
            if (sync_recv_en !== (t == 25) || sync_trans_en !== (t == 11)) begin
                n_errors++;
                $display("FAIL full_enables t=%0d got %b%b exp %b%b", t, sync_trans_en,
                         sync_recv_en, t == 11, t == 25);
            end
            n_checks++;
            if (busy !== (t >= 11 && t <= 44) || tx_ready !== (t == 21)) begin
                n_errors++;
                $display("FAIL full_busy_txr t=%0d got %b%b exp %b%b", t, busy, tx_ready,
                         t >= 11 && t <= 44, t == 21);
            end
            rx_frame_valid = (t == 5);
            cycle_start    = (t == 10);
            trans_done     = (t == 20);
            recv_done      = (t == 40);
            step();
        end
        {rx_frame_valid, cycle_start, trans_done, recv_done} = '0;
        n_checks++;
        if (cycle_cnt !== (STAT ? 16'd1 : 16'd0)) begin
            n_errors++;
            $display("FAIL full_cycle_cnt got %0d exp %0d", cycle_cnt, STAT ? 1 : 0);
        end
    endtask

    task automatic test_exclusion();
        logic [1:0] prev, cur, last_nz;
        int gap, ph, direct_viol, gap_viol, n_rx, n_fault, n_wait;
        do_reset();
        prev = 2'b00; last_nz = 2'b00;
        gap = 0; ph = 0; direct_viol = 0; gap_viol = 0; n_rx = 0; n_fault = 0;
        for (int t = 0; t < 1000; t++) begin
            cur = afpga_owner;
            if (fault) n_fault++;
            if (cur == 2'b00) begin
                gap++;
                ph = 0;
            end else begin
                ph++;
                if (prev != 2'b00 && prev != cur) direct_viol++;
                if (prev == 2'b00 && last_nz != 2'b00 && last_nz != cur && gap < GUARD) gap_viol++;
                if (cur == 2'b10 && prev != 2'b10) n_rx++;
                last_nz = cur;
                gap = 0;
            end
            prev = cur;
            cycle_start    = !busy && ($urandom_range(0, 1) == 0);
            rx_frame_valid = ($urandom_range(0, 7) == 0);
            trans_done     = (cur == 2'b01) && (ph >= 8 || $urandom_range(0, 3) == 0);
            recv_done      = (cur == 2'b10) && (ph >= 8 || $urandom_range(0, 3) == 0);
            step();
        end
        {cycle_start, rx_frame_valid, trans_done, recv_done} = '0;
        n_wait = 0;
        while (busy && n_wait < 40) begin
            recv_done = (afpga_owner == 2'b10);
            trans_done = (afpga_owner == 2'b01);
            step();
            n_wait++;
        end
        {trans_done, recv_done} = '0;
        n_checks++;
        if (direct_viol !== 0) begin
            n_errors++;
            $display("FAIL excl_direct got %0d exp 0", direct_viol);
        end
        n_checks++;
        if (gap_viol !== 0) begin
            n_errors++;
            $display("FAIL excl_gap got %0d exp 0", gap_viol);
        end
        n_checks++;
        if (n_fault !== 0 || busy !== 1'b0) begin
            n_errors++;
            $display("FAIL excl_fault_idle got fault_cycles=%0d busy=%b exp 0/0", n_fault, busy);
        end
        n_checks++;
        if (n_rx < 5) begin
            n_errors++;
            $display("FAIL excl_rx_phases got %0d exp >=5", n_rx);
        end
    endtask

    task automatic test_timeout();
        logic [1:0] e_own;
        logic       e_busy;
        do_reset();
        for (int t = 0; t <= 32; t++) begin
            e_own  = ((t >= 1 && t <= 16) || (t >= 24 && t <= 26)) ? 2'b01 : 2'b00;
            e_busy = (t >= 1 && t <= 21) || (t >= 24 && t <= 30);
            n_checks++;
            if (timeout_err !== (t == 17) || fault !== (t >= 17 && t <= 21)) begin
                n_errors++;
                $display("FAIL to_err_fault t=%0d got %b%b exp %b%b", t, timeout_err, fault,
                         t == 17, t >= 17 && t <= 21);
            end
            n_checks++;
            if (afpga_owner !== e_own || busy !== e_busy) begin
                n_errors++;
                $display("FAIL to_owner_busy t=%0d got %b/%b exp %b/%b", t, afpga_owner, busy,
                         e_own, e_busy);
            end
            n_checks++;
            if (sync_trans_en !== (t == 1 || t == 24) || tx_ready !== (t == 27)) begin
                n_errors++;
                $display("FAIL to_restart t=%0d got %b%b exp %b%b", t, sync_trans_en, tx_ready,
                         t == 1 || t == 24, t == 27);
            end
            cycle_start = (t == 0 || t == 19 || t == 23);
            fault_clr   = (t == 21);
            trans_done  = (t == 26);
            step();
        end
        {cycle_start, fault_clr, trans_done} = '0;
        n_checks++;
        if (overrun_cnt !== (STAT ? 8'd1 : 8'd0) || cycle_cnt !== (STAT ? 16'd1 : 16'd0)) begin
            n_errors++;
            $display("FAIL to_stats got %0d/%0d exp %0d/%0d", overrun_cnt, cycle_cnt,
                     STAT ? 1 : 0, STAT ? 1 : 0);
        end
    endtask

    task automatic test_overrun();
        int n_wait;
        do_reset();
        for (int t = 0; t <= 9; t++) begin
            cycle_start = (t == 0 || t == 2 || t == 4 || t == 6);
            trans_done  = (t == 8);
            step();
        end
        {cycle_start, trans_done} = '0;
        n_checks++;
        if (overrun_cnt !== (STAT ? 8'd3 : 8'd0)) begin
            n_errors++;
            $display("FAIL ovr_three got %0d exp %0d", overrun_cnt, STAT ? 3 : 0);
        end
        n_wait = 0;
        while (busy && n_wait < 20) begin
            step();
            n_wait++;
        end
        cycle_start = 1'b1;
        step();
        cycle_start = 1'b0;
        n_wait = 0;
        while (!fault && n_wait < 40) begin
            step();
            n_wait++;
        end
        n_checks++;
        if (fault !== 1'b1) begin
            n_errors++;
            $display("FAIL ovr_reach_fault got %b exp 1", fault);
        end
        for (int i = 0; i < 300; i++) begin
            cycle_start = 1'b1;
            step();
            cycle_start = 1'b0;
            if (i == 250) begin
                n_checks++;
                if (overrun_cnt !== (STAT ? 8'd254 : 8'd0)) begin
                    n_errors++;
                    $display("FAIL ovr_254 got %0d exp %0d", overrun_cnt, STAT ? 254 : 0);
                end
            end
            if (i == 251) begin
                n_checks++;
                if (overrun_cnt !== (STAT ? 8'd255 : 8'd0)) begin
                    n_errors++;
                    $display("FAIL ovr_255 got %0d exp %0d", overrun_cnt, STAT ? 255 : 0);
                end
            end
            step();
        end
        n_checks++;
        if (overrun_cnt !== (STAT ? 8'd255 : 8'd0) || busy !== 1'b1) begin
            n_errors++;
            $display("FAIL ovr_saturate got %0d busy=%b exp %0d busy=1", overrun_cnt, busy,
                     STAT ? 255 : 0);
        end
        fault_clr = 1'b1;
        step();
        fault_clr = 1'b0;
        n_checks++;
        if (fault !== 1'b0 || busy !== 1'b0) begin
            n_errors++;
            $display("FAIL ovr_fault_clr got fault=%b busy=%b exp 0/0", fault, busy);
        end
    endtask

    task automatic test_rx_requeue();
        logic [1:0] e_own, e_btoa;
        logic       e_busy;
        do_reset();
        for (int t = 0; t <= 33; t++) begin
            e_own  = ((t >= 3 && t <= 5) || (t >= 20 && t <= 22)) ? 2'b01 :
                     ((t >= 10 && t <= 12) || t == 27) ? 2'b10 : 2'b00;
            e_btoa = (t >= 10 && t <= 12) ? 2'b01 : (t == 27) ? 2'b11 : 2'b00;
            e_busy = (t >= 3 && t <= 16) || (t >= 20 && t <= 31);
            n_checks++;
            if (afpga_owner !== e_own || sync_Btoa_en !== e_btoa) begin
                n_errors++;
                $display("FAIL rq_owner_btoa t=%0d got %b/%b exp %b/%b", t, afpga_owner,
                         sync_Btoa_en, e_own, e_btoa);
            end
            n_checks++;
            if (sync_recv_en !== (t == 10 || t == 27) || busy !== e_busy) begin
                n_errors++;
                $display("FAIL rq_recv_busy t=%0d got %b/%b exp %b/%b", t, sync_recv_en, busy,
                         t == 10 || t == 27, e_busy);
            end
            n_checks++;
            if (tx_ready !== (t == 6 || t == 23) || sync_trans_en !== (t == 3 || t == 20)) begin
                n_errors++;
                $display("FAIL rq_tx t=%0d got %b%b exp %b%b", t, tx_ready, sync_trans_en,
                         t == 6 || t == 23, t == 3 || t == 20);
            end
            rx_frame_valid = (t == 0 || t == 10);
            cycle_start    = (t == 2 || t == 16 || t == 19);
            btoa_sel       = (t == 2) ? 2'b01 : (t == 19) ? 2'b11 : 2'b00;
            trans_done     = (t == 5 || t == 11 || t == 22);
            recv_done      = (t == 12 || t == 27);
            step();
        end
        {rx_frame_valid, cycle_start, trans_done, recv_done} = '0;
        btoa_sel = 2'b00;
        n_checks++;
        if (overrun_cnt !== (STAT ? 8'd1 : 8'd0) || cycle_cnt !== (STAT ? 16'd2 : 16'd0)) begin
            n_errors++;
            $display("FAIL rq_stats got %0d/%0d exp %0d/%0d", overrun_cnt, cycle_cnt,
                     STAT ? 1 : 0, STAT ? 2 : 0);
        end
    endtask

    initial begin
        test_reset();
        test_tx_only();
        test_full_cycle();
        test_exclusion();
        test_timeout();
        test_overrun();
        test_rx_requeue();
        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule

// File: doc/sync_sched.md
# sync_sched

Sequencing controller for the inter-FPGA sync datapath. Each control cycle it runs the transmit phase first, then the receive phase, and it guarantees the two phases never overlap on the shared AFPGA address bus, which is formed by OR-ing the addresses of both phases. It sits between the station timing logic and `sync_trans` / `sync_recv`. It drives their enables, tracks their completion, inserts guard gaps between phases, and watches for hangs.

## Interface
Parameters:
- `GUARD_CYC`, default 4: idle cycles between phases with the bus unowned; legal range 1..15.
- `TIMEOUT_W`, default 12: width of the wait timeout counter; a phase times out after 2^TIMEOUT_W−1 cycles.

Ports:
- `clk`  in  1  system clock; single clock domain.
- `reset`  in  1  synchronous, active-high reset.
- `cycle_start`  in  1  one-cycle pulse marking the start of a control cycle.
- `rx_frame_valid`  in  1  pulse: a complete frame has landed in the rx buffer.
- `btoa_sel`  in  2  receive direction selection; captured at cycle start.
- `trans_done`  in  1  pulse from the transmit engine when its copy is complete.
- `recv_done`  in  1  pulse from the receive engine when its copy is complete.
- `fault_clr`  in  1  pulse that clears a latched fault.
- `sync_trans_en`  out  1  one-cycle start pulse to the transmit engine.
- `sync_recv_en`  out  1  one-cycle start pulse to the receive engine.
- `sync_Btoa_en`  out  2  direction to the receive engine; valid while the receive phase owns the bus, otherwise 0.
- `afpga_owner`  out  2  current bus owner: 00 none, 01 transmit, 10 receive.
- `tx_ready`  out  1  one-cycle pulse: the tx buffer holds a fresh frame for the link.
- `busy`  out  1  high in every state except IDLE.
- `timeout_err`  out  1  one-cycle pulse when a wait times out.
- `fault`  out  1  sticky fault flag.
- `overrun_cnt`  out  8  count of `cycle_start` pulses dropped while busy; saturates at 255.
- `cycle_cnt`  out  16  count of completed cycles; wraps.

## Operation
- States: IDLE, T_START, T_WAIT, G1, R_START, R_WAIT, G2, FAULT.
- IDLE + `cycle_start`:
  - Capture `btoa_sel` into `dir_q`.
  - Move to T_START.
- T_START: `sync_trans_en`=1 for this state's single cycle, then move to T_WAIT.
- T_WAIT:
  - On `trans_done`: `tx_ready` pulses next cycle; move to G1.
  - `trans_done` arriving in T_START is also accepted and goes straight to G1.
- G1 lasts GUARD_CYC cycles, then:
  - go to R_START if `rx_pend`=1;
  - otherwise go to IDLE and increment `cycle_cnt`.
- R_START:
  - `sync_recv_en`=1 for one cycle.
  - Clear `rx_pend`.
  - Move to R_WAIT.
- R_WAIT: on `recv_done` (also accepted in R_START), move to G2.
- G2 lasts GUARD_CYC cycles, then go to IDLE and increment `cycle_cnt`.
- `rx_pend`:
  - Set by `rx_frame_valid` in any state.
  - If a set and the R_START clear happen in the same cycle, the set wins, so the frame is serviced in the next cycle.
- `afpga_owner`:
  - 01 in T_START and T_WAIT.
  - 10 in R_START and R_WAIT.
  - 00 in all other states.
- `sync_Btoa_en` = `dir_q` while owner is 10, otherwise 0.
- Timeout:
  - A TIMEOUT_W-bit counter clears on entry to T_WAIT or R_WAIT and increments every wait cycle.
  - When it reaches all-ones with no done: `timeout_err` pulses, `fault` is set, and the state goes to FAULT.
- FAULT:
  - Owner is 00 and `busy`=1.
  - All `cycle_start` pulses are ignored and counted as overruns.
  - `fault_clr` returns the state to IDLE and clears `fault`; `rx_pend` is kept.
- Overrun: `cycle_start` in any state other than IDLE increments `overrun_cnt`, saturating at 255. The pulse is otherwise dropped.
- A done pulse that arrives outside its wait state is ignored.

## Timing
- Reset: state IDLE. Every output is 0, and `rx_pend`, `dir_q` and all counters are 0.
- Reset mid-operation: all outputs are 0 on the next edge. In-flight engine work is not aborted by this block.
- `cycle_start` at cycle N (in IDLE):
  - `sync_trans_en`=1, `afpga_owner`=01 and `busy`=1 at N+1.
- `trans_done` at cycle M (in T_WAIT):
  - `tx_ready`=1 and `afpga_owner`=00 at M+1.
  - `sync_recv_en`=1 at M+1+GUARD_CYC.
- `recv_done` at cycle K: `busy` drops at K+1+GUARD_CYC.
- All outputs are registered; there are no combinational paths from inputs to outputs.
- `cycle_start` coinciding with the G2→IDLE transition is counted as an overrun, not accepted.

## Configuration
- `SYNC_SCHED_STAT_EN`:
  - Defined: `overrun_cnt` and `cycle_cnt` are implemented as described.
  - Undefined: both are tied to 0, their registers are omitted, and the state machine is unaffected.

## Test plan
- Transmit only, GUARD_CYC=4, `rx_pend`=0: `cycle_start`@10, `trans_done`@20 → `sync_trans_en`@11, `tx_ready`@21, `busy` falls @25, `cycle_cnt`=1, `sync_recv_en` never asserts.
- Full cycle: `rx_frame_valid`@5, `btoa_sel`=2'b10, `cycle_start`@10, `trans_done`@20, `recv_done`@40 → `sync_recv_en`@25, `sync_Btoa_en`=10 during @25–40, `busy` falls @45.
- Exclusion: random done delays over 1000 cycles → `afpga_owner` never changes directly between 01 and 10, and there are ≥GUARD_CYC cycles of 00 between the two phases.
- Timeout, TIMEOUT_W=4: `cycle_start` with no `trans_done` → `timeout_err` 15 cycles after entering T_WAIT, `fault`=1; `fault_clr` → IDLE; the next `cycle_start` starts normally.
- Overrun: 3 `cycle_start` pulses while busy → `overrun_cnt`=3. Holding overruns for 300 pulses → `overrun_cnt`=255.
- `rx_frame_valid` in the R_START cycle → a second receive phase runs in the following control cycle.
